// File: rtl/tri_op_pkg.sv
// ---------------------------------------------------------------------------
// tri_op_pkg
// Shared definitions for the three-operand reduction sequencer:
//   - operation encodings for the shared operator unit
//   - sequencer FSM state type
//   - default datapath width
// ---------------------------------------------------------------------------
package tri_op_pkg;

    localparam int WIDTH_DEFAULT = 8;

    localparam logic [1:0] OP_SUM = 2'd0;
    localparam logic [1:0] OP_MAX = 2'd1;
    localparam logic [1:0] OP_MIN = 2'd2;
    localparam logic [1:0] OP_XOR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PASS_AB = 2'd1,
        ST_PASS_C  = 2'd2,
        ST_OUT     = 2'd3
    } state_e;

endpackage

// File: rtl/tri_op_sequencer_op_unit.sv
// ---------------------------------------------------------------------------
// op_unit
// Registered two-operand operator shared by both reduction passes.
// One cycle latency; q/carry_q only update while en=1, so they hold the
// last result otherwise.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   en            update q/carry_q this cycle
//   x, y          operands
//   op            operation (OP_SUM/OP_MAX/OP_MIN/OP_XOR)
//   q             registered result
//   carry_q       registered carry-out (SUM only, 0 for other ops)
// ---------------------------------------------------------------------------
module op_unit
    import tri_op_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] q,
    output logic             carry_q
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_d;
    logic             carry_d;

    always_comb begin
        sum     = {1'b0, x} + {1'b0, y};
        res_d   = '0;
        carry_d = 1'b0;
        case (op)
            OP_SUM: begin
                res_d   = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
            end
            OP_MAX:  res_d = (x >= y) ? x : y;
            OP_MIN:  res_d = (x <= y) ? x : y;
            default: res_d = x ^ y;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            carry_q <= 1'b0;
        end else if (en) begin
            q       <= res_d;
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/tri_op_sequencer.sv
// ---------------------------------------------------------------------------
// tri_op_sequencer
// Computes d = a op b op c by running one shared op_unit twice:
// first (a op b), then (result op c). Valid/ready on both sides.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | in_ready=1, capture a/b/c/op on in_valid
// PASS_AB  | unit computes a_q op b_q
// PASS_C   | unit computes unit_q op c_q, pass-1 carry folded into acc
// OUT      | out_valid=1, hold d/ovf until out_ready
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   operand handshake
//   a, b, c, op          operands and operation
//   out_valid, out_ready result handshake
//   d, ovf               result, SUM overflow flag
//   busy                 high whenever not IDLE
// ---------------------------------------------------------------------------
module tri_op_sequencer
    import tri_op_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             ovf,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [1:0]       op_q, op_d;
    logic             ovf_acc_q, ovf_acc_d;

    logic             unit_en;
    logic [WIDTH-1:0] unit_x;
    logic [WIDTH-1:0] unit_y;
    logic [WIDTH-1:0] unit_q;
    logic             unit_carry_q;

    op_unit #(.WIDTH(WIDTH)) u_op_unit (
        .clk     (clk),
        .rst     (rst),
        .en      (unit_en),
        .x       (unit_x),
        .y       (unit_y),
        .op      (op_q),
        .q       (unit_q),
        .carry_q (unit_carry_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            op_q      <= OP_SUM;
            ovf_acc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            op_q      <= op_d;
            ovf_acc_q <= ovf_acc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        op_d      = op_q;
        ovf_acc_d = ovf_acc_q;
        unit_en   = 1'b0;
        unit_x    = a_q;
        unit_y    = b_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d       = a;
                    b_d       = b;
                    c_d       = c;
                    op_d      = op;
                    ovf_acc_d = 1'b0;
                    state_d   = ST_PASS_AB;
                end
            end
            ST_PASS_AB: begin
                unit_en = 1'b1;
                state_d = ST_PASS_C;
            end
            ST_PASS_C: begin
                unit_en   = 1'b1;
                unit_x    = unit_q;
                unit_y    = c_q;
                // unit_carry_q holds the pass-1 carry during this cycle
                ovf_acc_d = ovf_acc_q | unit_carry_q;
                state_d   = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // in_ready is forced low during reset, not just after it.
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_IDLE);
    assign d         = out_valid ? unit_q : '0;
    // Pass-2 carry sits in the unit register, frozen while in OUT (en=0).
    assign ovf       = out_valid && (op_q == OP_SUM) && (ovf_acc_q | unit_carry_q);

endmodule

// File: tb/tb_tri_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tri_op_sequencer
// Directed vectors with hand-computed results; expected results are queued
// at acceptance and a negedge monitor pops/compares on each output handshake.
// ---------------------------------------------------------------------------
module tb_tri_op_sequencer;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         ovf;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [1:0]   op;
        logic [W-1:0] d;
        logic         ovf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b, c;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         ovf;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;
    int n_pushed = 0;
    int n_popped = 0;
    int cyc = 0;

    exp_t exp_q[$];

    tri_op_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int got, input int expv);
        n_total++;
        if (got == expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
        end
    endtask

    // Monitor: one pop per output handshake.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_popped++;
                check("result_d", int'(d), int'(e.d));
                check("result_ovf", int'(ovf), int'(e.ovf));
            end
        end
    end

    // Presents one operand set; returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [W-1:0] tc, input logic [1:0] top,
                         input logic [W-1:0] ed, input logic eo, input bit push);
        bit ok;
        exp_t e;
        @(posedge clk); #1;
        a = ta; b = tb; c = tc; op = top; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        if (push) begin
            e.d = ed;
            e.ovf = eo;
            exp_q.push_back(e);
            n_pushed++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); c = W'($urandom); op = 2'($urandom);
    endtask

    // Counts edges (accepting edge = 1) until out_valid is seen; ends at that negedge.
    task automatic wait_out(input int exp_edges);
        int cnt;
        cnt = 1;
        @(negedge clk);
        while (!out_valid && cnt < 12) begin
            @(negedge clk);
            cnt++;
        end
        check("latency_edges", cnt, exp_edges);
    endtask

    task automatic run_one(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic [W-1:0] tc, input logic [1:0] top,
                           input logic [W-1:0] ed, input logic eo);
        issue(ta, tb, tc, top, ed, eo, 1'b1);
        wait_out(3);
        check({tag, "_in_ready_in_out"}, int'(in_ready), 0);
        @(negedge clk);
        check({tag, "_in_ready_back"}, int'(in_ready), 1);
        check({tag, "_busy_idle"}, int'(busy), 0);
    endtask

    vec_t vecs[6];
    int   acc_cyc[6];

    initial begin
        bit   ok;
        int   idx;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c = '0; op = '0; out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_d", int'(d), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_busy", int'(busy), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);

        // Single operations
        run_one("sum_small",  8'd10,  8'd20,  8'd30,  2'd0, 8'd60,  1'b0);
        run_one("sum_ovf",    8'd200, 8'd100, 8'd50,  2'd0, 8'd94,  1'b1);
        run_one("sum_ovf_p1", 8'd255, 8'd1,   8'd0,   2'd0, 8'd0,   1'b1);
        run_one("max",        8'd7,   8'd250, 8'd3,   2'd1, 8'd250, 1'b0);
        run_one("min",        8'd9,   8'd4,   8'd200, 2'd2, 8'd4,   1'b0);
        run_one("xor",        8'hF0,  8'h0F,  8'hFF,  2'd3, 8'h00,  1'b0);

        // Backpressure: SUM 100,100,100 -> 44, overflow only in pass 2
        out_ready = 1'b0;
        issue(8'd100, 8'd100, 8'd100, 2'd0, 8'd44, 1'b1, 1'b1);
        wait_out(3);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            a = W'($urandom); b = W'($urandom); c = W'($urandom);
            op = 2'($urandom); in_valid = ~in_valid;
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_d_held", int'(d), 44);
            check("bp_ovf_held", int'(ovf), 1);
            check("bp_in_ready", int'(in_ready), 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_after_out_valid", int'(out_valid), 0);
        check("bp_after_in_ready", int'(in_ready), 1);
        check("bp_single_handshake", n_popped, n_pushed);

        // Reset during PASS_C of SUM 1,2,3: result must never appear
        issue(8'd1, 8'd2, 8'd3, 2'd0, 8'd6, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_d", int'(d), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_result", int'(out_valid), 0);
        end
        run_one("max_after_rst", 8'd1, 8'd2, 8'd3, 2'd1, 8'd3, 1'b0);

        // Back-to-back stream with in_valid held high
        vecs[0] = '{a: 8'd1,   b: 8'd2,   c: 8'd3,   op: 2'd0, d: 8'd6,   ovf: 1'b0};
        vecs[1] = '{a: 8'd5,   b: 8'd9,   c: 8'd7,   op: 2'd1, d: 8'd9,   ovf: 1'b0};
        vecs[2] = '{a: 8'd200, b: 8'd150, c: 8'd180, op: 2'd2, d: 8'd150, ovf: 1'b0};
        vecs[3] = '{a: 8'hAA,  b: 8'h55,  c: 8'h0F,  op: 2'd3, d: 8'hF0,  ovf: 1'b0};
        vecs[4] = '{a: 8'd128, b: 8'd128, c: 8'd1,   op: 2'd0, d: 8'd1,   ovf: 1'b1};
        vecs[5] = '{a: 8'd3,   b: 8'd4,   c: 8'd5,   op: 2'd0, d: 8'd12,  ovf: 1'b0};
        @(posedge clk); #1;
        idx = 0;
        a = vecs[0].a; b = vecs[0].b; c = vecs[0].c; op = vecs[0].op; in_valid = 1'b1;
        for (int t = 0; t < 60 && idx < 6; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_t e;
                e.d = vecs[idx].d;
                e.ovf = vecs[idx].ovf;
                exp_q.push_back(e);
                n_pushed++;
                acc_cyc[idx] = cyc;
                @(posedge clk); #1;
                idx++;
                if (idx == 6) begin
                    in_valid = 1'b0;
                end else begin
                    a = vecs[idx].a; b = vecs[idx].b; c = vecs[idx].c; op = vecs[idx].op;
                end
            end
        end
        in_valid = 1'b0;
        check("stream_accepts", idx, 6);
        for (int i = 1; i < 6; i++) begin
            if (i < idx) check("stream_interval", acc_cyc[i] - acc_cyc[i-1], 4);
        end

        // Drain
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_done", int'(ok), 1);
        check("all_results_seen", n_popped, n_pushed);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
